jtag_debug_cmd_dispatch: RTL and testbench
==========================================

Name: jtag_debug_cmd_dispatch

Overview:
Sysclk-side command dispatcher for the multi-core debug fabric. It is the parametrised successor of the single-CPU JTAG sysclk action decoder. It takes a captured debug shift-register word, instruction code and core select from the TCK domain via toggle events. It then issues one valid/ack command to the selected Nios II debug core and returns that core's 32-bit response to the TCK side, with timeout and error reporting.

Parameters:
SR_W, 38, shift-register/jdo width
IR_W, 2, virtual-JTAG instruction width
NUM_CORES, 4, number of debug targets; power of 2, >=2
SEL_W, $clog2(NUM_CORES)+1, core-select width; MSB = broadcast/invalid bit
SYNC_STAGES, 2, synchroniser depth for toggle inputs, >=2
TIMEOUT, 255, clk cycles allowed for ack, 1..65535

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
sr  in  SR_W  TCK-domain shift-register snapshot; stable around udr_tgl
ir_in  in  IR_W  TCK-domain instruction; stable around uir_tgl/udr_tgl
core_sel  in  SEL_W  TCK-domain target select; stable around udr_tgl
udr_tgl  in  1  toggles once per update-DR
uir_tgl  in  1  toggles once per update-IR
cmd_ack  in  NUM_CORES  per-core acknowledge
rsp_data  in  NUM_CORES*32  per-core response; core k = bits [32k+31:32k]
jdo  out  SR_W  registered command payload
cmd_ir  out  IR_W  registered instruction for the command
cmd_valid  out  NUM_CORES  per-core command request
rsp_out  out  32  registered response to TCK side
rsp_tgl  out  1  toggles once per completed command
busy  out  1  high when the FSM is not in IDLE
status  out  3  sticky {overrun, bad_sel, timeout}

Behaviour:
- Reset: jdo=0, cmd_ir=0, cmd_valid=0, rsp_out=0, rsp_tgl=0, busy=0, status=0, FSM=IDLE, sync chains=0, timer=0.
- Sync: each toggle passes through SYNC_STAGES flops plus one delay flop. Event = last stage XOR delay flop. One-cycle pulse; latency SYNC_STAGES+1 clk from toggle.
- uir event (any state): cmd_ir <= ir_in; status <= 0.
- udr event in IDLE: jdo <= sr; latched_sel <= core_sel. cmd_ir <= ir_in, unless a uir event lands in the same cycle; in that case uir handling applies first, then the capture uses the same ir_in. Next state ISSUE.
- udr event outside IDLE: dropped; status[2] (overrun) <= 1; no other effect.
- ISSUE (1 cycle): timer <= 0.
  - If latched_sel MSB=1 (feature off): status[1] <= 1, rsp_out <= 32'hFFFF_FFFF, flip rsp_tgl, go IDLE. No cmd_valid is asserted.
  - Else: cmd_valid[latched_sel] <= 1, go WAIT.
- WAIT: cmd_valid held stable until completion; the timer increments each cycle.
  - Completion: cmd_ack[latched_sel]=1 with cmd_valid high. In that cycle, rsp_out <= rsp_data slice, flip rsp_tgl. Next cycle: cmd_valid=0, state IDLE.
  - Ack on non-selected cores is ignored.
  - Timeout: timer==TIMEOUT-1 without ack. Then cmd_valid <= 0, status[0] <= 1, rsp_out <= 32'hFFFF_FFFF, flip rsp_tgl, go IDLE.
  - Ack and timeout in the same cycle: the ack wins.
- Command latency: udr event to cmd_valid high = 2 clk. Ack to rsp_tgl flip = 1 clk.
- busy = (FSM != IDLE), registered with the FSM.
- reset mid-command drops cmd_valid next edge; rsp_tgl returns to 0. TCK side treats this as resync.
- status bits are sticky; they clear only on a uir event or reset.

Optional Feature:
Macro JTAG_DISPATCH_BCAST_EN.
- Defined: latched_sel MSB=1 means broadcast. ISSUE asserts all cmd_valid bits. Each bit deasserts on its own ack, and the acks are collected in a register. Completion occurs when all are collected; rsp_out = core 0 response. On timeout, status[0] is set and rsp_out = all-ones.
- Undefined: MSB=1 is bad_sel, as above; no ack-collect register is built.

Test Plan:
- Reset, then toggle udr_tgl with sr=38'h2A_1234_5678, ir_in=2'b01, core_sel=2 -> cmd_valid=4'b0100 exactly 2 clk after the event pulse, and jdo=38'h2A_1234_5678, cmd_ir=1. Ack after 5 cycles with rsp_data core2=32'hCAFE_0001 -> rsp_out=32'hCAFE_0001, rsp_tgl=1, busy=0 next cycle.
- No ack, TIMEOUT=8 -> cmd_valid drops after 8 WAIT cycles, status=3'b001, rsp_out=32'hFFFF_FFFF. Then a uir_tgl toggle -> status=0.
- Second udr toggle while WAIT -> status[2]=1, no new capture, jdo unchanged, first command completes normally.
- core_sel=4 with feature off -> no cmd_valid, status[1]=1, rsp_tgl flips.
- Feature on, core_sel=4, acks from cores 3,0,2,1 on different cycles -> each valid bit falls on its ack, completion 1 clk after the last ack, rsp_out=core0 data.
- Assert reset during WAIT -> cmd_valid=0, rsp_tgl=0, busy=0 at the next edge.

Source files
------------

// File: rtl/jtag_debug_cmd_dispatch.sv
// Sysclk-side dispatcher: turns TCK-domain update-DR/IR toggles into one valid/ack command per debug core.
// Optional broadcast to all cores when JTAG_DISPATCH_BCAST_EN is defined; otherwise a select MSB of 1 is bad_sel.
//
// state    | meaning
// ST_IDLE  | waiting for an update-DR event
// ST_ISSUE | one cycle: check select, raise cmd_valid or report bad select
// ST_WAIT  | cmd_valid held, timer running until ack or timeout
module jtag_debug_cmd_dispatch #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int NUM_CORES   = 4,
  parameter int SEL_W       = $clog2(NUM_CORES) + 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SR_W-1:0]         sr,
  input  logic [IR_W-1:0]         ir_in,
  input  logic [SEL_W-1:0]        core_sel,
  input  logic                    udr_tgl,
  input  logic                    uir_tgl,
  input  logic [NUM_CORES-1:0]    cmd_ack,
  input  logic [NUM_CORES*32-1:0] rsp_data,
  output logic [SR_W-1:0]         jdo,
  output logic [IR_W-1:0]         cmd_ir,
  output logic [NUM_CORES-1:0]    cmd_valid,
  output logic [31:0]             rsp_out,
  output logic                    rsp_tgl,
  output logic                    busy,
  output logic [2:0]              status
);

  localparam int IDX_W = SEL_W - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_dly;
  logic                   uir_dly;
  logic [SEL_W-1:0]       latched_sel;
  logic [15:0]            timer;

  logic                   udr_evt;
  logic                   uir_evt;
  logic [IDX_W-1:0]       sel_idx;
  logic [31:0]            sel_rsp;
  logic                   sel_ack;
  logic                   timer_done;

`ifdef JTAG_DISPATCH_BCAST_EN
  logic [NUM_CORES-1:0]   ack_coll;
  logic [NUM_CORES-1:0]   ack_coll_next;
  logic [31:0]            bc_rsp;
`endif

  assign udr_evt    = udr_sync[SYNC_STAGES-1] ^ udr_dly;
  assign uir_evt    = uir_sync[SYNC_STAGES-1] ^ uir_dly;
  assign sel_idx    = latched_sel[IDX_W-1:0];
  assign timer_done = (timer == 16'(TIMEOUT - 1));

  always_comb begin
    sel_rsp = '0;
    sel_ack = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (k == int'(sel_idx)) begin
        sel_rsp = rsp_data[k*32 +: 32];
        sel_ack = cmd_ack[k];
      end
    end
  end

`ifdef JTAG_DISPATCH_BCAST_EN
  assign ack_coll_next = ack_coll | (cmd_ack & cmd_valid);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      udr_sync    <= '0;
      uir_sync    <= '0;
      udr_dly     <= 1'b0;
      uir_dly     <= 1'b0;
      latched_sel <= '0;
      timer       <= '0;
      jdo         <= '0;
      cmd_ir      <= '0;
      cmd_valid   <= '0;
      rsp_out     <= '0;
      rsp_tgl     <= 1'b0;
      busy        <= 1'b0;
      status      <= '0;
`ifdef JTAG_DISPATCH_BCAST_EN
      ack_coll    <= '0;
      bc_rsp      <= '0;
`endif
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], udr_tgl};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], uir_tgl};
      udr_dly  <= udr_sync[SYNC_STAGES-1];
      uir_dly  <= uir_sync[SYNC_STAGES-1];

      // uir clear comes first so any status set later in this cycle survives
      if (uir_evt) begin
        cmd_ir <= ir_in;
        status <= '0;
      end
      if (udr_evt && state != ST_IDLE) status[2] <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (udr_evt) begin
            jdo         <= sr;
            latched_sel <= core_sel;
            cmd_ir      <= ir_in;
            state       <= ST_ISSUE;
            busy        <= 1'b1;
          end
        end

        ST_ISSUE: begin
          timer <= '0;
          if (latched_sel[SEL_W-1]) begin
`ifdef JTAG_DISPATCH_BCAST_EN
            cmd_valid <= '1;
            ack_coll  <= '0;
            state     <= ST_WAIT;
`else
            status[1] <= 1'b1;
            rsp_out   <= 32'hFFFF_FFFF;
            rsp_tgl   <= ~rsp_tgl;
            state     <= ST_IDLE;
            busy      <= 1'b0;
`endif
          end else begin
            cmd_valid[sel_idx] <= 1'b1;
            state              <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          timer <= timer + 16'd1;
`ifdef JTAG_DISPATCH_BCAST_EN
          if (latched_sel[SEL_W-1]) begin
            cmd_valid <= cmd_valid & ~cmd_ack;
            ack_coll  <= ack_coll_next;
            if (cmd_ack[0] && cmd_valid[0]) bc_rsp <= rsp_data[31:0];
            if (&ack_coll_next) begin
              cmd_valid <= '0;
              rsp_out   <= (cmd_ack[0] && cmd_valid[0]) ? rsp_data[31:0] : bc_rsp;
              rsp_tgl   <= ~rsp_tgl;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end else if (timer_done) begin
              cmd_valid <= '0;
              status[0] <= 1'b1;
              rsp_out   <= 32'hFFFF_FFFF;
              rsp_tgl   <= ~rsp_tgl;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end
          end else
`endif
          begin
            if (sel_ack && cmd_valid[sel_idx]) begin
              cmd_valid <= '0;
              rsp_out   <= sel_rsp;
              rsp_tgl   <= ~rsp_tgl;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end else if (timer_done) begin
              cmd_valid <= '0;
              status[0] <= 1'b1;
              rsp_out   <= 32'hFFFF_FFFF;
              rsp_tgl   <= ~rsp_tgl;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_debug_cmd_dispatch.sv
// Randomized bench for jtag_debug_cmd_dispatch against a per-command outcome model.
// Broadcast cases follow JTAG_DISPATCH_BCAST_EN; without it core_sel=4 must report bad_sel.
module tb_jtag_debug_cmd_dispatch;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [37:0]  sr = '0;
  logic [1:0]   ir_in = '0;
  logic [2:0]   core_sel = '0;
  logic         udr_tgl = 1'b0;
  logic         uir_tgl = 1'b0;
  logic [3:0]   cmd_ack = '0;
  logic [127:0] rsp_data = '0;
  logic [37:0]  jdo;
  logic [1:0]   cmd_ir;
  logic [3:0]   cmd_valid;
  logic [31:0]  rsp_out;
  logic         rsp_tgl;
  logic         busy;
  logic [2:0]   status;

  int       n_cmp = 0;
  int       n_err = 0;
  logic     exp_tgl = 1'b0;
  logic [2:0] exp_status = '0;
  int       bc_dly[4];

  jtag_debug_cmd_dispatch #(
    .SR_W(38), .IR_W(2), .NUM_CORES(4), .SEL_W(3), .SYNC_STAGES(2), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .core_sel(core_sel),
    .udr_tgl(udr_tgl), .uir_tgl(uir_tgl), .cmd_ack(cmd_ack), .rsp_data(rsp_data),
    .jdo(jdo), .cmd_ir(cmd_ir), .cmd_valid(cmd_valid), .rsp_out(rsp_out),
    .rsp_tgl(rsp_tgl), .busy(busy), .status(status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full command: toggle udr, follow the handshake, check the outcome.
  // dly = WAIT cycles before the selected core acks (>= TO means never).
  task automatic run_cmd(input logic [37:0] s, input logic [1:0] ir, input logic [2:0] sel,
                         input int dly, input bit ovr);
    int dl[4];
    int maxd;
    int last;
    int si;
    logic [3:0] en;
    logic [3:0] want;
    logic [3:0] drv;
    logic [31:0] exp_rsp;
    bit bc;
    si = int'(sel[1:0]);
    bc = sel[2];
    @(negedge clk);
    sr = s; ir_in = ir; core_sel = sel; udr_tgl = ~udr_tgl;
    repeat (4) @(negedge clk);
    check_eq("jdo_capture", 64'(jdo), 64'(s));
    check_eq("cmd_ir_capture", 64'(cmd_ir), 64'(ir));
`ifndef JTAG_DISPATCH_BCAST_EN
    if (bc) begin
      exp_status[1] = 1'b1;
      exp_tgl = ~exp_tgl;
      check_eq("badsel_valid", 64'(cmd_valid), 64'(0));
      check_eq("badsel_rsp", 64'(rsp_out), 64'hFFFF_FFFF);
      check_eq("badsel_tgl", 64'(rsp_tgl), 64'(exp_tgl));
      check_eq("badsel_status", 64'(status), 64'(exp_status));
      check_eq("badsel_busy", 64'(busy), 64'(0));
      return;
    end
`endif
    en = bc ? 4'hF : 4'(1 << si);
    maxd = 0;
    for (int j = 0; j < 4; j++) begin
      dl[j] = bc ? bc_dly[j] : ((j == si) ? dly : 1000);
      if (en[j] && dl[j] > maxd) maxd = dl[j];
    end
    last = (maxd < TO) ? maxd : TO - 1;
    for (int k = 0; k <= last; k++) begin
      want = '0;
      drv = '0;
      for (int j = 0; j < 4; j++) begin
        if (en[j] && dl[j] >= k) want[j] = 1'b1;
        if (en[j] && dl[j] == k) drv[j] = 1'b1;
      end
      check_eq("valid_wait", 64'(cmd_valid), 64'(want));
      check_eq("busy_wait", 64'(busy), 64'(1));
      if (!bc) drv = drv | (4'($urandom) & ~en);
      cmd_ack = drv;
      if (ovr && last >= 4 && k == 1) begin
        sr = ~s;
        udr_tgl = ~udr_tgl;
        exp_status[2] = 1'b1;
      end
      @(negedge clk);
    end
    cmd_ack = '0;
    if (maxd < TO) begin
      exp_rsp = bc ? rsp_data[31:0] : rsp_data[si*32 +: 32];
    end else begin
      exp_rsp = 32'hFFFF_FFFF;
      exp_status[0] = 1'b1;
    end
    exp_tgl = ~exp_tgl;
    check_eq("done_valid", 64'(cmd_valid), 64'(0));
    check_eq("done_busy", 64'(busy), 64'(0));
    check_eq("done_rsp", 64'(rsp_out), 64'(exp_rsp));
    check_eq("done_tgl", 64'(rsp_tgl), 64'(exp_tgl));
    check_eq("done_status", 64'(status), 64'(exp_status));
    check_eq("done_jdo", 64'(jdo), 64'(s));
  endtask

  task automatic do_uir(input logic [1:0] ir);
    @(negedge clk);
    ir_in = ir; uir_tgl = ~uir_tgl;
    repeat (4) @(negedge clk);
    exp_status = '0;
    check_eq("uir_ir", 64'(cmd_ir), 64'(ir));
    check_eq("uir_status", 64'(status), 64'(0));
  endtask

  initial begin
    logic [2:0] rsel;
    repeat (3) @(negedge clk);
    check_eq("rst_jdo", 64'(jdo), 64'(0));
    check_eq("rst_valid", 64'(cmd_valid), 64'(0));
    check_eq("rst_rsp", 64'(rsp_out), 64'(0));
    check_eq("rst_tgl_busy_status", 64'({rsp_tgl, busy, status, cmd_ir}), 64'(0));
    reset = 1'b0;

    rsp_data = {32'h3333_3333, 32'hCAFE_0001, 32'h1111_1111, 32'h0000_0B0B};
    run_cmd(38'h2A_1234_5678, 2'b01, 3'd2, 5, 1'b0);

    run_cmd(38'h01_0000_00FF, 2'b10, 3'd1, 1000, 1'b0);
    do_uir(2'b11);

    run_cmd(38'h15_5555_5555, 2'b00, 3'd3, 6, 1'b1);
    do_uir(2'b00);

    bc_dly[0] = 1; bc_dly[1] = 3; bc_dly[2] = 2; bc_dly[3] = 0;
    run_cmd(38'h3F_0F0F_0F0F, 2'b01, 3'd4, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      rsp_data = {$urandom, $urandom, $urandom, $urandom};
      rsel = 3'($urandom_range(0, 4));
      for (int j = 0; j < 4; j++) bc_dly[j] = $urandom_range(0, 9);
      run_cmd({6'($urandom), 32'($urandom)}, 2'($urandom), rsel,
              $urandom_range(0, 10), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) do_uir(2'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset while a command is in WAIT
    @(negedge clk);
    sr = 38'h00_DEAD_BEEF; core_sel = 3'd1; udr_tgl = ~udr_tgl;
    repeat (6) @(negedge clk);
    check_eq("pre_rst_valid", 64'(cmd_valid), 64'(4'b0010));
    reset = 1'b1; udr_tgl = 1'b0; uir_tgl = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", 64'(cmd_valid), 64'(0));
    check_eq("midrst_tgl", 64'(rsp_tgl), 64'(0));
    check_eq("midrst_busy", 64'(busy), 64'(0));
    check_eq("midrst_status", 64'(status), 64'(0));
    reset = 1'b0; exp_tgl = 1'b0; exp_status = '0;
    repeat (2) @(negedge clk);
    rsp_data = {32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
    run_cmd(38'h12_3456_789A, 2'b10, 3'd0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
